// File: rtl/yarp_mem_arbiter.sv
// Purpose: shares one memory port between the fetch (I) and data (D) requesters, one transaction at a time; YARP_ARB_RR_EN selects round-robin over fixed D-over-I.
// Latency: req seen in cycle N -> mem_req_o in N+1 -> ack in N+2 with zero-wait memory; all outputs registered.
// Backpressure: requests are held until their ack; mem_req_o is held until mem_gnt_i; a TIMEOUT-cycle abort guarantees progress.
module yarp_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ack_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic        d_wr_i,
    input  logic [1:0]  d_byte_en_i,
    input  logic [31:0] d_wr_data_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  byte_en;
        logic [31:0] wr_data;
    } mem_cmd_t;

    localparam int unsigned CW = $clog2(TIMEOUT + 2);
    // Fetches are always full-word reads.
    localparam logic [1:0] FETCH_SIZE = 2'b10;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 1 = D owns the port
    logic [CW-1:0] cnt_q, cnt_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        mem_req_q, mem_req_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        i_elig, d_elig, pick_d;
    logic        timeout_hit;
    logic        resp_done, timed_out;
    logic [31:0] resp_data;

    // A requester whose ack is on this cycle is not re-issued.
    assign i_elig = i_req_i & ~i_ack_q;
    assign d_elig = d_req_i & ~d_ack_q;

`ifdef YARP_ARB_RR_EN
    logic last_d_q, last_d_d;

    assign pick_d = d_elig & (~i_elig | ~last_d_q);

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (i_elig || d_elig)) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d = d_elig;
`endif

    // Abort on the cycle that completes TIMEOUT counted REQ/RSP cycles.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        mem_req_d = mem_req_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        resp_done = 1'b0;
        timed_out = 1'b0;
        resp_data = 32'd0;

        case (state_q)
            IDLE: begin
                if (i_elig || d_elig) begin
                    owner_d   = pick_d;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                    if (pick_d) begin
                        cmd_d = '{addr: d_addr_i, wr: d_wr_i,
                                  byte_en: d_byte_en_i, wr_data: d_wr_data_i};
                    end else begin
                        cmd_d = '{addr: i_addr_i, wr: 1'b0,
                                  byte_en: FETCH_SIZE, wr_data: 32'd0};
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_gnt_i && mem_rvalid_i) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                end else if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid_i) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_done || timed_out) begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            err_d     = timed_out;
            resp_data = timed_out ? 32'd0 : mem_rd_data_i;
            if (owner_q) begin
                d_ack_d   = 1'b1;
                d_rdata_d = resp_data;
            end else begin
                i_ack_d   = 1'b1;
                i_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            mem_req_q <= mem_req_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ack_o       = i_ack_q;
    assign i_rdata_o     = i_rdata_q;
    assign d_ack_o       = d_ack_q;
    assign d_rdata_o     = d_rdata_q;
    assign err_o         = err_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = cmd_q.addr;
    assign mem_wr_o      = cmd_q.wr;
    assign mem_byte_en_o = cmd_q.byte_en;
    assign mem_wr_data_o = cmd_q.wr_data;

endmodule
